// File: rtl/tis_pkg.sv
// rtl/tis_pkg.sv - shared constants and types for the TIS node row and its program loader
package tis_pkg;

    localparam int NODES     = 12;
    localparam int MAX_INSTR = 15;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [15:0] instr_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_WHI,
        LD_WLO,
        LD_CSUM
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchroniser and start-bit glitch rejection
module uart_rx
    import tis_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // Line must still be low at mid start bit, otherwise it was a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a checksum-verified program image from UART into the instruction and length stores
module prog_loader #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int NODES     = tis_pkg::NODES,
    parameter int MAX_INSTR = tis_pkg::MAX_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        len_we,
    output logic [3:0]  len_addr,
    output logic [3:0]  len_wdata,
    output logic        run,
    output logic        loaded,
    output logic        err
);

    import tis_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DEPTH        = NODES * MAX_INSTR;

    localparam logic [3:0] LAST_NODE = 4'(NODES - 1);
    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;

    ld_state_t  state;
    logic [3:0] node_idx;
    logic [7:0] word_addr;
    logic [7:0] hi_byte;
    logic [7:0] csum;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LD_IDLE;
            node_idx  <= '0;
            word_addr <= '0;
            hi_byte   <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_we    <= 1'b0;
            len_addr  <= '0;
            len_wdata <= '0;
            run       <= 1'b0;
            loaded    <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            len_we <= 1'b0;
            loaded <= 1'b0;
            if (frame_err && state != LD_IDLE) begin
                err   <= 1'b1;
                run   <= 1'b0;
                state <= LD_IDLE;
            end else if (rx_valid) begin
                case (state)
                    LD_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state     <= LD_LEN;
                            err       <= 1'b0;
                            run       <= 1'b0;
                            node_idx  <= '0;
                            word_addr <= '0;
                            csum      <= '0;
                        end
                    end
                    LD_LEN: begin
                        // The offending length is still written; the store is partial after an error anyway.
                        len_we    <= 1'b1;
                        len_addr  <= node_idx;
                        len_wdata <= rx_data[3:0];
                        csum      <= csum ^ rx_data;
                        node_idx  <= node_idx + 1'b1;
                        if (rx_data[7:4] != 4'd0) begin
                            err   <= 1'b1;
                            state <= LD_IDLE;
                        end else if (node_idx == LAST_NODE) begin
                            state <= LD_WHI;
                        end
                    end
                    LD_WHI: begin
                        hi_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                        state   <= LD_WLO;
                    end
                    LD_WLO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_addr;
                        mem_wdata <= instr_t'({hi_byte, rx_data});
                        csum      <= csum ^ rx_data;
                        word_addr <= word_addr + 1'b1;
                        state     <= (word_addr == LAST_ADDR) ? LD_CSUM : LD_WHI;
                    end
                    LD_CSUM: begin
                        if (rx_data == csum) begin
                            run    <= 1'b1;
                            loaded <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= LD_IDLE;
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    import tis_pkg::*;

    localparam int CPB       = 3;
    localparam int DEPTH     = NODES * MAX_INSTR;
    localparam int FRAME_LEN = 1 + NODES + 2 * DEPTH + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_line = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        len_we;
    logic [3:0]  len_addr;
    logic [3:0]  len_wdata;
    logic        run;
    logic        loaded;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(
        .CLK_HZ    (300_000),
        .BAUD      (100_000),
        .NODES     (NODES),
        .MAX_INSTR (MAX_INSTR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (rx_line),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .len_we    (len_we),
        .len_addr  (len_addr),
        .len_wdata (len_wdata),
        .run       (run),
        .loaded    (loaded),
        .err       (err)
    );

    typedef struct {
        bit          is_len;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  lenv;
        logic [15:0] pat;
        logic [7:0]  csum_x;
        int          bad_len_node;
        int          stop_err_byte;
        int          abort_at;
        bit          lead_zero;
        bit          exp_err;
        bit          exp_run;
        int          exp_loaded;
    } case_t;

    wr_t   sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_rxv_cyc = -10;
    logic [7:0] last_rxv_data = 8'h00;
    int    rxv_cnt = 0;
    int    loaded_cnt = 0;
    logic  prev_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and timing monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_run = run;
        end else begin
            if (dut.u_rx.rx_valid) begin
                rxv_cnt++;
                last_rxv_cyc  = cyc;
                last_rxv_data = dut.u_rx.rx_data;
            end
            if (len_we || mem_we) begin
                wr_t e;
                check("strobe_latency", cyc, last_rxv_cyc + 1);
                if (sb.size() == 0) begin
                    check("unexpected_write", {len_we, mem_we}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("write_kind", len_we, e.is_len);
                    if (e.is_len) begin
                        check("len_addr", len_addr, e.addr[3:0]);
                        check("len_wdata", len_wdata, e.data[3:0]);
                    end else begin
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wdata", mem_wdata, e.data);
                    end
                end
            end
            if (loaded) begin
                loaded_cnt++;
                check("loaded_latency", cyc, last_rxv_cyc + 1);
                check("run_rise_with_loaded", {prev_run, run}, 2'b01);
            end
            if (prev_run && !run) begin
                check("run_fall_latency", cyc, last_rxv_cyc + 1);
                check("run_fall_on_sync", last_rxv_data, SYNC_BYTE);
            end
            prev_run = run;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_line = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input case_t c);
        logic [7:0]  fb [FRAME_LEN];
        logic [7:0]  cs;
        logic [15:0] w;
        int          last;
        cs = 8'h00;
        fb[0] = SYNC_BYTE;
        for (int n = 0; n < NODES; n++) fb[1 + n] = {4'h0, c.lenv};
        if (c.bad_len_node >= 0) fb[1 + c.bad_len_node] = 8'h1F;
        for (int a = 0; a < DEPTH; a++) begin
            w = 16'(a) ^ c.pat;
            fb[1 + NODES + 2 * a]     = w[15:8];
            fb[1 + NODES + 2 * a + 1] = w[7:0];
        end
        for (int i = 1; i < FRAME_LEN - 1; i++) cs = cs ^ fb[i];
        fb[FRAME_LEN - 1] = cs ^ c.csum_x;
        last = FRAME_LEN - 1;
        if (c.abort_at >= 0) last = c.abort_at;
        if (c.bad_len_node >= 0) last = 1 + c.bad_len_node;
        if (c.stop_err_byte >= 0) last = c.stop_err_byte;
        if (c.lead_zero) send_byte(8'h00, 1'b1);
        for (int i = 0; i <= last; i++) begin
            if (i == c.stop_err_byte) begin
                send_byte(fb[i], 1'b0);
            end else begin
                if (i >= 1 && i <= NODES) begin
                    sb.push_back('{1'b1, 8'(i - 1), {12'h000, fb[i][3:0]}});
                end else if (i > NODES && i < FRAME_LEN - 1 && ((i - NODES - 1) % 2) == 1) begin
                    sb.push_back('{1'b0, 8'((i - NODES - 2) / 2), {fb[i - 1], fb[i]}});
                end
                send_byte(fb[i], 1'b1);
                if (i == 0) check("run_low_after_sync", run, 1'b0);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_run"}, run, 1'b0);
        check({tag, "_loaded"}, loaded, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_len_we"}, len_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 8'h00);
        check({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
        check({tag, "_len_addr"}, len_addr, 4'h0);
        check({tag, "_len_wdata"}, len_wdata, 4'h0);
        check({tag, "_state"}, 32'(dut.state), 32'(LD_IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t cases [6];
        case_t c_abort;
        case_t c_after;
        int    l0;
        int    r0;
        logic  err_before;

        //            lenv   pat       csum_x bad  stop abrt lz  err  run  ld
        cases[0] = '{4'd1, 16'h0000, 8'h00, -1,  -1,  -1, 1'b0, 1'b0, 1'b1, 1};
        cases[1] = '{4'd2, 16'h5A00, 8'h00, -1,  -1,  -1, 1'b1, 1'b0, 1'b1, 1};
        cases[2] = '{4'd1, 16'h0000, 8'h01, -1,  -1,  -1, 1'b0, 1'b1, 1'b0, 0};
        cases[3] = '{4'd1, 16'h0000, 8'h00,  3,  -1,  -1, 1'b0, 1'b1, 1'b0, 0};
        cases[4] = '{4'd3, 16'h3C3C, 8'h00, -1,  -1,  -1, 1'b0, 1'b0, 1'b1, 1};
        cases[5] = '{4'd1, 16'h0000, 8'h00, -1,  63,  -1, 1'b0, 1'b1, 1'b0, 0};
        c_abort  = '{4'd1, 16'h0000, 8'h00, -1,  -1, 193, 1'b0, 1'b0, 1'b0, 0};
        c_after  = '{4'd4, 16'hA5A5, 8'h00, -1,  -1,  -1, 1'b0, 1'b0, 1'b1, 1};

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_outputs_zero("post_reset");

        for (int c = 0; c < 6; c++) begin
            l0 = loaded_cnt;
            send_frame(cases[c]);
            repeat (30) @(negedge clk);
            check($sformatf("case%0d_sb_empty", c), sb.size(), 0);
            check($sformatf("case%0d_err", c), err, cases[c].exp_err);
            check($sformatf("case%0d_run", c), run, cases[c].exp_run);
            check($sformatf("case%0d_loaded", c), loaded_cnt - l0, cases[c].exp_loaded);
            check($sformatf("case%0d_state", c), 32'(dut.state), 32'(LD_IDLE));
        end

        // One-cycle low glitch on an idle line must not produce a byte.
        r0 = rxv_cnt;
        err_before = err;
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rx_valid", rxv_cnt - r0, 0);
        check("glitch_err_unchanged", err, err_before);

        // Reset in the middle of the word section, then a full reload.
        send_frame(c_abort);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_reset_sb_empty", sb.size(), 0);
        check("mid_reset_run", run, 1'b0);
        l0 = loaded_cnt;
        send_frame(c_after);
        repeat (30) @(negedge clk);
        check("reload_sb_empty", sb.size(), 0);
        check("reload_err", err, 1'b0);
        check("reload_run", run, 1'b1);
        check("reload_loaded", loaded_cnt - l0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader feeding the TIS node row. Receives a program image over a UART line (8N1) and writes it into the instruction store (180 × 16-bit words) and the per-node length store (12 × 4-bit). Holds the node row stopped (`run` low) while an image loads, and releases it only after a checksum-verified image is complete. Sits directly upstream of the row, replacing the fixed power-on program image as the source of program contents.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, serial bit rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (434 at defaults).
- `NODES`, 12, number of nodes in the image.
- `MAX_INSTR`, 15, instruction slots per node; store depth = `NODES*MAX_INSTR` = 180.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low.**
- `uart_rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `mem_we`  out  1  one-cycle instruction-store write strobe.
- `mem_addr`  out  8  instruction-store address, 0..179.
- `mem_wdata`  out  16  instruction word.
- `len_we`  out  1  one-cycle length-store write strobe.
- `len_addr`  out  4  node index, 0..11.
- `len_wdata`  out  4  program length for that node, 0..15.
- `run`  out  1  high means the node row may execute; low holds it in reset.
- `loaded`  out  1  one-cycle pulse when a verified image completes.
- `err`  out  1  sticky; set on a bad frame and cleared by the next sync byte.

## Operation
- Frame format: sync byte `0xA5`; then 12 length bytes, node 0 first, with the value in bits [3:0] and bits [7:4] required to be 0; then 180 words, each high byte first, at addresses 0..179 in order; then 1 checksum byte.
- Checksum is the XOR of every byte after the sync byte, excluding the checksum byte itself.
- The receiver syncs `uart_rx` through 2 flops.
  - A falling edge starts a frame. The receiver waits `CLKS_PER_BIT/2` clocks and re-checks for low; if the line is high, it treats the edge as a glitch and returns to idle.
  - It samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
  - A stop bit of 0 is a framing error.
  - On each good byte it pulses `rx_valid` for 1 cycle with `rx_data`.
- Loader FSM states: IDLE, LEN, WHI, WLO, CSUM.
  - IDLE: a `0xA5` byte moves to LEN, clears `err`, zeroes the counters and checksum, and drops `run`. Any other byte is ignored.
  - LEN: each byte is written to the length store at the next node index. If bits [7:4] ≠ 0, go to IDLE with `err` set. After node 11, go to WHI.
  - WHI: latch the high byte, then go to WLO.
  - WLO: write `{hi, byte}` to `mem_addr`, then increment the address. After address 179, go to CSUM; otherwise go back to WHI.
  - CSUM: on a match, set `run`, pulse `loaded`, and go to IDLE. On a mismatch, set `err`, keep `run` low, and go to IDLE.
- A framing error in any state other than IDLE sets `err`, keeps `run` low, and returns to IDLE.
- A `0xA5` byte inside a frame is data, not a resync.
- After an error, store contents are partial. `run` stays low until a full good frame arrives.

## Timing
- Reset values: `run`=0, `loaded`=0, `err`=0, `mem_we`=0, `len_we`=0, all address and data outputs 0, FSM in IDLE.
- Reset mid-frame aborts the load; no further writes occur.
- All outputs are registered.
- Write strobes assert exactly 1 cycle after the `rx_valid` of the completing byte. Address and data are valid in the same cycle as the strobe.
- `run` falls 1 cycle after the sync byte's `rx_valid`.
- `run` rises, and `loaded` pulses, 1 cycle after the checksum byte's `rx_valid`.
- Byte latency from the stop-bit midpoint to `rx_valid` is ≤ 2 cycles. This excludes the 2-cycle synchroniser.
- Strobe spacing is ≥ 10 bit-times, so no write back-pressure exists.

## Structure
- Shared package `tis_pkg`:
  - `NODES` and `MAX_INSTR` constants.
  - `SYNC_BYTE` = `0xA5`.
  - Loader state enum.
  - Instruction word type `logic [15:0]`.
- Sub-module `uart_rx` (parameters `CLKS_PER_BIT`; ports `clk`, `rst_n`, `rx`, `rx_valid`, `rx_data[7:0]`, `frame_err`).
- The loader FSM lives in `prog_loader`.

## Test plan
- Full frame: lengths all 1, words = address (0x0000..0x00B3), correct checksum → 12 `len_we` with data 1, 180 `mem_we` with `mem_wdata == mem_addr`, then `run`=1 and one `loaded` pulse.
- Same frame with checksum XORed by 0x01 → all writes occur, `err`=1, `run` stays 0, no `loaded` pulse.
- Length byte 0x1F at node 3 → writes for nodes 0..3 occur, then `err`=1, no `mem_we`, FSM back in IDLE. The next good frame clears `err` and sets `run`.
- Stop bit forced to 0 on word byte 50 → `err`=1, writes stop at address 24. A glitch of 100 cycles low while idle → no `rx_valid`.
- Second good frame while `run`=1 → `run` drops 1 cycle after sync, rises after the new checksum, and the new data overwrites the store. A leading 0x00 byte before sync is ignored.
- `rst_n` asserted at word 90 → all outputs 0 immediately. After release, a full good frame loads correctly.
